// File: rtl/dbg_loader.sv
// UART byte-stream debug loader: decodes host commands into CPU reset control
// and 32-bit word accesses on the SoC debug memory port.
module dbg_loader #(
    parameter int unsigned TIMEOUT       = 100000,
    parameter bit          HOLD_AT_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        dbg_mem_op,
    output logic [3:0]  dbg_wren,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_do,
    input  logic [31:0] dbg_di,
    input  logic        dbg_ready,
    output logic        cpu_n_reset
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_H = 8'h48;
    localparam logic [7:0] OP_G = 8'h47;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    logic [2:0]       state_q,   state_d;
    logic [1:0]       cnt_q,     cnt_d;
    logic [TMO_W-1:0] tmo_q,     tmo_d;
    logic             is_wr_q,   is_wr_d;
    logic             rej_q,     rej_d;
    logic [31:0]      adr_q,     adr_d;
    logic [31:0]      do_q,      do_d;
    logic [3:0]       wren_q,    wren_d;
    logic             mem_op_q,  mem_op_d;
    logic [23:0]      buf_q,     buf_d;
    logic [1:0]       left_q,    left_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_vld_q,  tx_vld_d;
    logic             cpu_q,     cpu_d;

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 2'd0;
            tmo_q     <= '0;
            is_wr_q   <= 1'b0;
            rej_q     <= 1'b0;
            adr_q     <= 32'd0;
            do_q      <= 32'd0;
            wren_q    <= 4'h0;
            mem_op_q  <= 1'b0;
            buf_q     <= 24'd0;
            left_q    <= 2'd0;
            tx_data_q <= 8'h00;
            tx_vld_q  <= 1'b0;
            cpu_q     <= ~HOLD_AT_RESET;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            is_wr_q   <= is_wr_d;
            rej_q     <= rej_d;
            adr_q     <= adr_d;
            do_q      <= do_d;
            wren_q    <= wren_d;
            mem_op_q  <= mem_op_d;
            buf_q     <= buf_d;
            left_q    <= left_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            cpu_q     <= cpu_d;
        end
    end

    // Command decode, payload assembly, access handshake and reply sequencing
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        is_wr_d   = is_wr_q;
        rej_d     = rej_q;
        adr_d     = adr_q;
        do_d      = do_q;
        wren_d    = wren_q;
        mem_op_d  = mem_op_q;
        buf_d     = buf_q;
        left_d    = left_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = tx_vld_q;
        cpu_d     = cpu_q;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        OP_W, OP_R: begin
                            state_d = S_ADDR;
                            cnt_d   = 2'd0;
                            tmo_d   = '0;
                            is_wr_d = (rx_data == OP_W);
                            // Accesses are refused while the CPU is running
                            rej_d   = cpu_q;
                        end
                        OP_H, OP_G: begin
                            cpu_d     = (rx_data == OP_G);
                            state_d   = S_RESP;
                            tx_vld_d  = 1'b1;
                            tx_data_d = ACK;
                            left_d    = 2'd0;
                        end
                        default: begin
                            state_d   = S_RESP;
                            tx_vld_d  = 1'b1;
                            tx_data_d = NAK;
                            left_d    = 2'd0;
                        end
                    endcase
                end
            end

            S_ADDR, S_DATA: begin
                if (rx_valid) begin
                    tmo_d = '0;
                    cnt_d = cnt_q + 2'd1;
                    if (state_q == S_ADDR) begin
                        adr_d[{cnt_q, 3'b000} +: 8] = rx_data;
                        adr_d[1:0]                  = 2'b00;
                    end else begin
                        do_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    end
                    if (cnt_q == 2'd3) begin
                        if (state_q == S_ADDR && is_wr_q) begin
                            state_d = S_DATA;
                        end else if (rej_q) begin
                            state_d   = S_RESP;
                            tx_vld_d  = 1'b1;
                            tx_data_d = NAK;
                            left_d    = 2'd0;
                        end else begin
                            state_d  = S_MEM;
                            mem_op_d = 1'b1;
                            wren_d   = is_wr_q ? 4'hF : 4'h0;
                        end
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_MEM: begin
                if (dbg_ready) begin
                    mem_op_d  = 1'b0;
                    wren_d    = 4'h0;
                    state_d   = S_RESP;
                    tx_vld_d  = 1'b1;
                    buf_d     = dbg_di[31:8];
                    tx_data_d = is_wr_q ? ACK : dbg_di[7:0];
                    left_d    = is_wr_q ? 2'd0 : 2'd3;
                end
            end

            S_RESP: begin
                if (tx_vld_q) begin
                    if (tx_ready) begin
                        tx_vld_d = 1'b0;
                        if (left_q == 2'd0) begin
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    // Gap cycle after a transfer: present the next queued byte
                    tx_vld_d  = 1'b1;
                    tx_data_d = buf_q[7:0];
                    buf_d     = {8'h00, buf_q[23:8]};
                    left_d    = left_q - 2'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_vld_q;
    assign dbg_mem_op  = mem_op_q;
    assign dbg_wren    = wren_q;
    assign dbg_adr     = adr_q;
    assign dbg_do      = do_q;
    assign cpu_n_reset = cpu_q;

endmodule

// File: tb/tb_dbg_loader.sv
// Scoreboard bench for dbg_loader: expected accesses and reply bytes are queued
// as commands are sent and retired by monitors on the debug port and UART tx.
module tb_dbg_loader;

    localparam int unsigned TMO = 40;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic [31:0] dbg_di;
    logic        dbg_ready;
    logic        cpu_n_reset;

    dbg_loader #(.TIMEOUT(TMO), .HOLD_AT_RESET(1'b1)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .dbg_mem_op  (dbg_mem_op),
        .dbg_wren    (dbg_wren),
        .dbg_adr     (dbg_adr),
        .dbg_do      (dbg_do),
        .dbg_di      (dbg_di),
        .dbg_ready   (dbg_ready),
        .cpu_n_reset (cpu_n_reset)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        chk_do;
        logic [3:0]  wren;
        logic [7:0]  len;
    } acc_t;

    acc_t        exp_acc[$];
    logic [7:0]  exp_tx[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          rd_delay = 0;
    logic [31:0] rd_word = 32'd0;
    int          tx_mode = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Debug port responder: completes each access rd_delay cycles after it starts
    initial begin : responder
        int wcnt;
        wcnt = 0;
        dbg_ready = 1'b0;
        dbg_di = 32'hdead_beef;
        forever begin
            @(posedge clk);
            #1;
            if (dbg_mem_op && !dbg_ready) begin
                if (wcnt >= rd_delay) begin
                    dbg_ready = 1'b1;
                    dbg_di = rd_word;
                end else begin
                    wcnt++;
                end
            end else begin
                dbg_ready = 1'b0;
                dbg_di = 32'hdead_beef;
                wcnt = 0;
            end
        end
    end

    // UART transmitter back-pressure: 0 always ready, 1 random stalls, 2 blocked
    initial begin : tx_drv
        forever begin
            if (tx_mode == 0)      tx_ready = 1'b1;
            else if (tx_mode == 1) tx_ready = 1'($urandom_range(0, 1));
            else                   tx_ready = 1'b0;
            @(posedge clk);
            #1;
        end
    end

    int         mem_cnt = 0;
    acc_t       cur = '0;
    logic       pv = 1'b0;
    logic [7:0] pd = 8'h00;

    // Monitors sample on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!n_reset) begin
            mem_cnt = 0;
            pv = 1'b0;
        end else begin
            if (dbg_mem_op) begin
                if (mem_cnt == 0) begin
                    if (exp_acc.size() == 0) begin
                        chk("acc_unexpected", 32'(exp_acc.size()), 32'd1);
                    end else begin
                        cur = exp_acc.pop_front();
                        chk("acc_adr", dbg_adr, cur.adr);
                        chk("acc_wren", 32'(dbg_wren), 32'(cur.wren));
                        if (cur.chk_do) chk("acc_do", dbg_do, cur.dat);
                    end
                end
                mem_cnt++;
                if (dbg_ready) begin
                    chk("acc_hold_adr", dbg_adr, cur.adr);
                    chk("acc_hold_wren", 32'(dbg_wren), 32'(cur.wren));
                    if (cur.len != 8'd0) chk("acc_len", 32'(mem_cnt), 32'(cur.len));
                    mem_cnt = 0;
                end
            end else begin
                mem_cnt = 0;
            end

            if (tx_valid) begin
                if (pv) chk("tx_stable", 32'(tx_data), 32'(pd));
                if (tx_ready) begin
                    if (exp_tx.size() == 0) chk("tx_unexpected", 32'(exp_tx.size()), 32'd1);
                    else                    chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                    pv = 1'b0;
                end else begin
                    pv = 1'b1;
                    pd = tx_data;
                end
            end else begin
                pv = 1'b0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick($urandom_range(0, 2));
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send(8'(w >> (8 * k)));
    endtask

    task automatic exp_access(input logic [31:0] adr, input logic [31:0] dat,
                              input logic chk_do, input logic [3:0] wren, input int len);
        acc_t a;
        a.adr = adr;
        a.dat = dat;
        a.chk_do = chk_do;
        a.wren = wren;
        a.len = 8'(len);
        exp_acc.push_back(a);
    endtask

    task automatic exp_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) exp_tx.push_back(8'(w >> (8 * k)));
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (exp_tx.size() == 0 && exp_acc.size() == 0 && !tx_valid && !dbg_mem_op) break;
            tick();
        end
        chk(tag, 32'(i < 3000), 32'd1);
        tick(3);
    endtask

    task automatic wait_sig(input string tag, input bit use_tx);
        int i;
        for (i = 0; i < 200; i++) begin
            if (use_tx ? tx_valid : dbg_mem_op) break;
            tick();
        end
        chk(tag, 32'(i < 200), 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        tick(3);
        chk("rst_mem_op", 32'(dbg_mem_op), 32'd0);
        chk("rst_wren", 32'(dbg_wren), 32'd0);
        chk("rst_adr", dbg_adr, 32'd0);
        chk("rst_do", dbg_do, 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_cpu", 32'(cpu_n_reset), 32'd0);
        n_reset = 1'b1;
        tick(2);

        // Word write
        rd_delay = 0;
        exp_access(32'h0002_0000, 32'h0001_07b7, 1'b1, 4'hF, 1);
        exp_tx.push_back(8'h06);
        send(8'h57); send_word(32'h0002_0000); send_word(32'h0001_07b7);
        wait_idle("write_done");

        // Word read, 6-cycle access, random tx stalls
        rd_delay = 5; rd_word = 32'h0007_a023; tx_mode = 1;
        exp_access(32'h0002_0004, 32'd0, 1'b0, 4'h0, 6);
        exp_word(32'h0007_a023);
        send(8'h52); send_word(32'h0002_0004);
        wait_idle("read_done");
        tx_mode = 0;

        // Release CPU, rejected write, hold CPU again
        exp_tx.push_back(8'h06);
        send(8'h47);
        wait_idle("go_done");
        chk("cpu_run", 32'(cpu_n_reset), 32'd1);
        exp_tx.push_back(8'h15);
        send(8'h57); send_word(32'h0000_1000); send_word(32'hcafe_f00d);
        wait_idle("reject_done");
        exp_tx.push_back(8'h06);
        send(8'h48);
        wait_idle("hold_done");
        chk("cpu_held", 32'(cpu_n_reset), 32'd0);

        // Inter-byte timeout drops the partial write
        send(8'h57); send(8'h01); send(8'h00);
        tick(TMO + 5);
        rd_delay = 1; rd_word = 32'h1234_5678;
        exp_access(32'h0000_0000, 32'd0, 1'b0, 4'h0, 2);
        exp_word(32'h1234_5678);
        send(8'h52); send_word(32'h0000_0000);
        wait_idle("timeout_read_done");

        // Unknown opcode, address low bits cleared, bytes during MEM dropped
        exp_tx.push_back(8'h15);
        send(8'h00);
        wait_idle("bad_op_done");
        rd_delay = 8;
        exp_access(32'h0000_0008, 32'h4433_2211, 1'b1, 4'hF, 9);
        exp_tx.push_back(8'h06);
        send(8'h57); send_word(32'h0000_000B);
        for (int k = 0; k < 4; k++) begin
            rx_data = 8'(8'h11 * (k + 1)); rx_valid = 1'b1; tick(); rx_valid = 1'b0;
            if (k < 3) tick(1);
        end
        send(8'h47); send(8'h57); send(8'h00);
        wait_idle("mem_drop_done");
        chk("cpu_after_drop", 32'(cpu_n_reset), 32'd0);

        // Reset during MEM
        exp_access(32'h0000_0010, 32'd0, 1'b0, 4'h0, 0);
        rd_delay = 30;
        send(8'h52); send_word(32'h0000_0010);
        wait_sig("mem_seen", 1'b0);
        tick(3);
        #2 n_reset = 1'b0;
        #1;
        chk("rmem_mem_op", 32'(dbg_mem_op), 32'd0);
        chk("rmem_tx_valid", 32'(tx_valid), 32'd0);
        chk("rmem_cpu", 32'(cpu_n_reset), 32'd0);
        chk("rmem_adr", dbg_adr, 32'd0);
        tick(2);
        n_reset = 1'b1;
        tick(2);

        // Reset during RESP
        rd_delay = 0; rd_word = 32'h5555_aaaa; tx_mode = 2;
        exp_access(32'h0000_0020, 32'd0, 1'b0, 4'h0, 1);
        send(8'h52); send_word(32'h0000_0020);
        wait_sig("resp_seen", 1'b1);
        tick(2);
        #2 n_reset = 1'b0;
        #1;
        chk("rresp_tx_valid", 32'(tx_valid), 32'd0);
        chk("rresp_tx_data", 32'(tx_data), 32'd0);
        chk("rresp_mem_op", 32'(dbg_mem_op), 32'd0);
        tick(2);
        tx_mode = 0;
        n_reset = 1'b1;
        tick(2);

        // Normal command after reset
        exp_access(32'h0000_0100, 32'h89ab_cdef, 1'b1, 4'hF, 1);
        exp_tx.push_back(8'h06);
        send(8'h57); send_word(32'h0000_0100); send_word(32'h89ab_cdef);
        wait_idle("post_reset_done");
        chk("final_acc_q", 32'(exp_acc.size()), 32'd0);
        chk("final_tx_q", 32'(exp_tx.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dbg_loader.md
# dbg_loader

Byte-stream debug loader sitting between the on-chip UART byte interface and the SoC debug memory port. It decodes host commands to hold or release the CPU reset and to write or read 32-bit words through the debug port (dbg_mem_op/dbg_wren/dbg_adr/dbg_do/dbg_di). It is the in-hardware driver of that port, so ROM/RAM can be programmed over UART while the CPU is held in reset.

## Interface
- TIMEOUT, 100000: inter-byte timeout in clk cycles while a command is incomplete.
- HOLD_AT_RESET, 1: cpu_n_reset value after n_reset is `!HOLD_AT_RESET`.
- clk  in  1  system clock.
- n_reset  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- tx_data  out  8  response byte.
- tx_valid  out  1  response byte pending.
- tx_ready  in  1  UART transmitter accepts tx_data when tx_valid && tx_ready.
- dbg_mem_op  out  1  debug access request.
- dbg_wren  out  4  byte write enables: 4'hF for writes, 4'h0 for reads.
- dbg_adr  out  32  word address; bits [1:0] always 0.
- dbg_do  out  32  write data.
- dbg_di  in  32  read data, valid when dbg_ready is high.
- dbg_ready  in  1  one-cycle completion strobe for the current access.
- cpu_n_reset  out  1  CPU reset, active-low.

## Operation
- Commands; multi-byte fields are LSB first:
  - 'W' (0x57) + 4 address bytes + 4 data bytes: word write, reply 0x06.
  - 'R' (0x52) + 4 address bytes: word read, reply 4 data bytes LSB first.
  - 'H' (0x48): cpu_n_reset=0, reply 0x06.
  - 'G' (0x47): cpu_n_reset=1, reply 0x06.
  - Any other opcode: reply 0x15, return to IDLE.
- A 'W' or 'R' issued while cpu_n_reset=1 consumes its full payload, performs no access, and replies 0x15.
- States:
  - IDLE: waits for an opcode.
  - ADDR: 4 bytes.
  - DATA: 4 bytes, W only.
  - MEM: access in progress.
  - RESP: sending the reply.
- A 2-bit byte counter advances per rx_valid. It wraps from 3 to 0 on the ADDR→DATA and DATA→MEM (or ADDR→MEM) transitions.
- Address bits [1:0] received from the host are discarded.
- In ADDR/DATA, the timeout counter reloads on every rx_valid. If it reaches TIMEOUT, the block returns to IDLE silently; no access, no reply.
- rx_valid in MEM or RESP is ignored; the byte is dropped.
- MEM has no timeout. It waits indefinitely for dbg_ready.

## Timing
- Reset values:
  - dbg_mem_op=0, dbg_wren=0, dbg_adr=0, dbg_do=0.
  - tx_valid=0, tx_data=0.
  - cpu_n_reset=!HOLD_AT_RESET.
  - State IDLE, counters 0.
- The cycle after the last payload byte: dbg_mem_op=1, with dbg_adr/dbg_do/dbg_wren stable. They are held until dbg_ready is sampled high.
- The cycle after dbg_ready: dbg_mem_op=0 and dbg_wren=0, tx_valid=1 with the first reply byte.
  - Read data is captured from dbg_di on the dbg_ready cycle.
  - dbg_ready coincident with the first dbg_mem_op cycle is legal, giving 1-cycle access.
- dbg_ready while dbg_mem_op=0 is ignored.
- tx_data is stable while tx_valid is high. The next byte is presented on the cycle after a transfer (at most 1 byte per 2 cycles). After the last byte transfers, tx_valid=0 and the state is IDLE the next cycle.
- 'H'/'G': cpu_n_reset changes the cycle after the opcode; tx_valid rises in the same cycle.
- Asserting n_reset mid-operation immediately returns all outputs to their reset values, including dropping dbg_mem_op and aborting the reply.

## Test plan
- After reset with HOLD_AT_RESET=1, send 'W' 00 00 02 00 b7 07 01 00 → one access with dbg_adr=0x00020000, dbg_do=0x000107b7, dbg_wren=4'hF; reply 0x06.
- Send 'R' 04 00 02 00 with dbg_di=0x0007a023 and dbg_ready delayed 5 cycles → dbg_mem_op high for exactly 6 cycles, dbg_wren=0; reply 23 a0 07 00, with tx_ready stalled randomly.
- Send 'G' → cpu_n_reset=1, reply 0x06. Then 'W' with 8 payload bytes → no dbg_mem_op, reply 0x15. Then 'H' → cpu_n_reset=0, reply 0x06.
- Send 'W' 01 00, wait TIMEOUT+1 cycles, then 'R' 00 00 00 00 → only the read executes, with dbg_adr=0 (the address byte 0x01 has bits [1:0] cleared).
- Send 0x00 → reply 0x15. Send 'W' with address byte 0x0B → dbg_adr[1:0]=0. Send extra bytes during MEM → they are ignored.
- Assert n_reset during MEM and during RESP → dbg_mem_op=0, tx_valid=0, cpu_n_reset=0 asynchronously. The next command executes normally.
